clause_bank: RTL and testbench

CLAUSE_BANK -- requirements
Module: clause_bank

---
 rtl/clause_bank.sv | 183 ++++++++++++++++++
 tb/tb_clause_bank.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_bank.sv
// Clause bank: holds clause slots and scans them one per cycle against the current variable
// assignment, reporting the first unit and first conflicting slot. Optional macro: SCAN_EARLY_EXIT_EN.
module clause_bank #(
    parameter int NUM_VARS    = 8,
    parameter int NUM_CLAUSES = 8,
    parameter int WIDTH_C_LEN = 4,
    parameter int WIDTH_IDX   = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_VARS*3-1:0]              var_value_i,
    input  logic [NUM_CLAUSES-1:0]             wr_i,
    input  logic [NUM_CLAUSES-1:0]             rd_i,
    input  logic [NUM_VARS*2-1:0]              clause_i,
    output logic [NUM_VARS*2-1:0]              clause_o,
    input  logic [WIDTH_C_LEN-1:0]             clause_len_i,
    output logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_o,
    input  logic                               start_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               conflict_o,
    output logic [WIDTH_IDX-1:0]               conflict_idx_o,
    output logic                               imp_valid_o,
    output logic [WIDTH_IDX-1:0]               imp_idx_o,
    output logic [NUM_VARS*2-1:0]              imp_lit_o,
    output logic                               all_c_sat_o,
    input  logic                               apply_impl_i,
    input  logic                               apply_bkt_i
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    typedef enum logic [1:0] {C_SAT, C_UNIT, C_CONFLICT, C_OPEN} cls_t;

    state_t                 state, state_nxt;
    logic [WIDTH_IDX-1:0]   idx;
    logic [NUM_VARS*2-1:0]  slots [NUM_CLAUSES];
    logic [WIDTH_C_LEN-1:0] lens  [NUM_CLAUSES];
    logic [NUM_CLAUSES-1:0] reason, reason_nxt, need_clear, need_clear_nxt;
    logic                   all_sat_acc;
    logic [NUM_VARS*2-1:0]  cur_clause, free_lit;
    logic                   any_true;
    logic [1:0]             free_cnt;
    cls_t                   cls;
    logic                   last_slot, scan_exit;
    logic                   unused_flag_bits;

    assign cur_clause = slots[idx];
    assign last_slot  = (idx == WIDTH_IDX'(NUM_CLAUSES - 1));

    // A literal is true when its code equals the variable's value code (01/01 or 10/10).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        any_true = 1'b0;
        free_cnt = 2'd0;
        free_lit = '0;
        cls      = C_OPEN;
        for (int v = 0; v < NUM_VARS; v++) begin
            if (cur_clause[2*v +: 2] != 2'b00) begin
                if (var_value_i[3*v +: 2] == 2'b00) begin
                    if (free_cnt != 2'd2) free_cnt = free_cnt + 2'd1;
                    free_lit[2*v +: 2] = cur_clause[2*v +: 2];
                end else if (var_value_i[3*v +: 2] == cur_clause[2*v +: 2]) begin
                    any_true = 1'b1;
                end
            end
        end
        if (cur_clause == '0 || any_true) cls = C_SAT;
        else if (free_cnt == 2'd1)        cls = C_UNIT;
        else if (free_cnt == 2'd0)        cls = C_CONFLICT;
        else                              cls = C_OPEN;
    end

`ifdef SCAN_EARLY_EXIT_EN
    assign scan_exit = last_slot || (cls == C_CONFLICT);
`else
    assign scan_exit = last_slot;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = SCAN;
            SCAN:    if (scan_exit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            all_sat_acc    <= 1'b0;
            conflict_o     <= 1'b0;
            conflict_idx_o <= '0;
            imp_valid_o    <= 1'b0;
            imp_idx_o      <= '0;
            imp_lit_o      <= '0;
            all_c_sat_o    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
            if (state == IDLE && start_i) begin
                idx            <= '0;
                all_sat_acc    <= 1'b1;
                conflict_o     <= 1'b0;
                conflict_idx_o <= '0;
                imp_valid_o    <= 1'b0;
                imp_idx_o      <= '0;
                imp_lit_o      <= '0;
                all_c_sat_o    <= 1'b0;
            end else if (state == SCAN) begin
                idx         <= idx + 1'b1;
                all_sat_acc <= all_sat_acc && (cls == C_SAT);
                if (cls == C_UNIT && !imp_valid_o) begin
                    imp_valid_o <= 1'b1;
                    imp_idx_o   <= idx;
                    imp_lit_o   <= free_lit;
                end
                if (cls == C_CONFLICT && !conflict_o) begin
                    conflict_o     <= 1'b1;
                    conflict_idx_o <= idx;
                end
                if (scan_exit) all_c_sat_o <= all_sat_acc && (cls == C_SAT);
            end
        end
    end

    // Backtrack clears flagged reasons before a same-cycle implication sets a new one.
    always_comb begin
        reason_nxt     = reason;
        need_clear_nxt = need_clear;
        if (state == IDLE) begin
            if (apply_bkt_i) begin
                reason_nxt     = reason & ~need_clear;
                need_clear_nxt = '0;
            end
            if (apply_impl_i && imp_valid_o) reason_nxt[imp_idx_o] = 1'b1;
            reason_nxt     = reason_nxt & ~wr_i;
            need_clear_nxt = need_clear_nxt & ~wr_i;
        end else if (state == SCAN && reason[idx]) begin
            if (cls == C_OPEN || cls == C_UNIT) need_clear_nxt[idx] = 1'b1;
            else if (cls == C_SAT)              need_clear_nxt[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the slot array is reset explicitly; a reset must leave every read at 0, so it lives in flops.
            for (int s = 0; s < NUM_CLAUSES; s++) begin
                slots[s] <= '0;
                lens[s]  <= '0;
            end
            reason     <= '0;
            need_clear <= '0;
        end else begin
            reason     <= reason_nxt;
            need_clear <= need_clear_nxt;
            if (state == IDLE) begin
                for (int s = 0; s < NUM_CLAUSES; s++) begin
                    if (wr_i[s]) begin
                        slots[s] <= clause_i;
                        lens[s]  <= clause_len_i;
                    end
                end
            end
        end
    end

    always_comb begin
        clause_o         = '0;
        clause_len_o     = '0;
        unused_flag_bits = 1'b0;
        for (int s = 0; s < NUM_CLAUSES; s++) begin
            if (rd_i[s]) clause_o = clause_o | slots[s];
            clause_len_o[s*WIDTH_C_LEN +: WIDTH_C_LEN] = reason[s] ? '0 : lens[s];
        end
        for (int v = 0; v < NUM_VARS; v++) unused_flag_bits = unused_flag_bits ^ var_value_i[3*v+2];
    end

    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

endmodule

// File: tb/tb_clause_bank.sv
// Randomized self-checking bench for clause_bank against a slot-list reference model.
module tb_clause_bank;
    localparam int NV = 8, NC = 8, WL = 4, WI = 3;
    localparam int K_SAT = 0, K_UNIT = 1, K_CONF = 2, K_OPEN = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NV*3-1:0] var_value_i;
    logic [NC-1:0]   wr_i, rd_i;
    logic [NV*2-1:0] clause_i, clause_o;
    logic [WL-1:0]   clause_len_i;
    logic [WL*NC-1:0] clause_len_o;
    logic            start_i, busy_o, done_o, conflict_o, imp_valid_o, all_c_sat_o;
    logic [WI-1:0]   conflict_idx_o, imp_idx_o;
    logic [NV*2-1:0] imp_lit_o;
    logic            apply_impl_i, apply_bkt_i;

    clause_bank dut (
        .clk(clk), .rst(rst), .var_value_i(var_value_i), .wr_i(wr_i), .rd_i(rd_i),
        .clause_i(clause_i), .clause_o(clause_o), .clause_len_i(clause_len_i),
        .clause_len_o(clause_len_o), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .conflict_o(conflict_o), .conflict_idx_o(conflict_idx_o), .imp_valid_o(imp_valid_o),
        .imp_idx_o(imp_idx_o), .imp_lit_o(imp_lit_o), .all_c_sat_o(all_c_sat_o),
        .apply_impl_i(apply_impl_i), .apply_bkt_i(apply_bkt_i)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    logic [NV*2-1:0] m_clause [NC];
    logic [WL-1:0]   m_len    [NC];
    bit              m_reason [NC];
    bit              m_need   [NC];
    bit              m_imp_valid;
    int              m_imp_idx;
    logic [NV*2-1:0] e_lit;
    bit              e_conf, e_all;
    int              e_cidx, e_lat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NC; s++) begin
            m_clause[s] = '0; m_len[s] = '0; m_reason[s] = 0; m_need[s] = 0;
        end
        m_imp_valid = 0; m_imp_idx = 0; e_lit = '0; e_conf = 0; e_cidx = 0; e_all = 0;
    endtask

    // Spec classification: count true and free literals of one clause.
    function automatic int classify(input logic [NV*2-1:0] c, input logic [NV*3-1:0] vals,
                                    output logic [NV*2-1:0] lit);
        int n_true = 0, n_free = 0;
        lit = '0;
        for (int v = 0; v < NV; v++) begin
            logic [1:0] l, x;
            l = c[2*v +: 2];
            x = vals[3*v +: 2];
            if (l != 2'b00) begin
                if (x == 2'b00) begin
                    n_free++;
                    lit = '0;
                    lit[2*v +: 2] = l;
                end else if ((l == 2'b01 && x == 2'b01) || (l == 2'b10 && x == 2'b10)) begin
                    n_true++;
                end
            end
        end
        if (c == '0 || n_true > 0) return K_SAT;
        if (n_free == 1) return K_UNIT;
        if (n_free == 0) return K_CONF;
        return K_OPEN;
    endfunction

    task automatic model_scan(input logic [NV*3-1:0] vals);
        int k;
        logic [NV*2-1:0] lit;
        bit all;
        e_conf = 0; e_cidx = 0; m_imp_valid = 0; m_imp_idx = 0; e_lit = '0; all = 1;
        e_lat = NC + 1;
        for (int s = 0; s < NC; s++) begin
            k = classify(m_clause[s], vals, lit);
            if (m_reason[s]) begin
                if (k == K_UNIT || k == K_OPEN) m_need[s] = 1;
                else if (k == K_SAT)            m_need[s] = 0;
            end
            if (k != K_SAT) all = 0;
            if (k == K_UNIT && !m_imp_valid) begin
                m_imp_valid = 1; m_imp_idx = s; e_lit = lit;
            end
            if (k == K_CONF && !e_conf) begin
                e_conf = 1; e_cidx = s;
`ifdef SCAN_EARLY_EXIT_EN
                e_lat = s + 2;
                break;
`endif
            end
        end
        e_all = all;
    endtask

    task automatic write_slot(input int s, input logic [NV*2-1:0] c, input logic [WL-1:0] len);
        wr_i = NC'(1 << s); clause_i = c; clause_len_i = len;
        @(posedge clk); #1;
        wr_i = '0;
        m_clause[s] = c; m_len[s] = len; m_reason[s] = 0; m_need[s] = 0;
    endtask

    task automatic apply_cmd(input bit impl, input bit bkt);
        apply_impl_i = impl; apply_bkt_i = bkt;
        @(posedge clk); #1;
        apply_impl_i = 0; apply_bkt_i = 0;
        if (bkt)
            for (int s = 0; s < NC; s++)
                if (m_need[s]) begin m_reason[s] = 0; m_need[s] = 0; end
        if (impl && m_imp_valid) m_reason[m_imp_idx] = 1;
    endtask

    task automatic check_reads(input logic [NC-1:0] rd);
        logic [NV*2-1:0] exp_c;
        logic [WL*NC-1:0] exp_l;
        exp_c = '0; exp_l = '0;
        for (int s = 0; s < NC; s++) begin
            if (rd[s]) exp_c = exp_c | m_clause[s];
            exp_l[s*WL +: WL] = m_reason[s] ? '0 : m_len[s];
        end
        rd_i = rd;
        #1;
        check("clause_o", clause_o, exp_c);
        check("clause_len_o", clause_len_o, exp_l);
        rd_i = '0;
    endtask

    task automatic run_scan(input logic [NV*3-1:0] vals);
        int cyc;
        model_scan(vals);
        var_value_i = vals; start_i = 1;
        @(posedge clk); #1;
        start_i = 0; cyc = 1;
        check("busy_scan", busy_o, 1);
        while (!done_o && cyc < 40) begin
            if (cyc == 3) begin
                start_i = 1; wr_i = NC'(1 << $urandom_range(0, NC-1));
                clause_i = NV*2'($urandom); clause_len_i = WL'($urandom);
            end
            @(posedge clk); #1;
            cyc++; start_i = 0; wr_i = '0;
        end
        check("latency", cyc, e_lat);
        check("conflict", conflict_o, e_conf);
        check("conflict_idx", conflict_idx_o, e_cidx);
        check("imp_valid", imp_valid_o, m_imp_valid);
        check("imp_idx", imp_idx_o, m_imp_idx);
        check("imp_lit", imp_lit_o, e_lit);
        check("all_c_sat", all_c_sat_o, e_all);
        @(posedge clk); #1;
        check("idle_after_done", {busy_o, done_o}, 0);
        check("held_conflict", conflict_o, e_conf);
        check("held_imp_valid", imp_valid_o, m_imp_valid);
    endtask

    function automatic logic [NV*2-1:0] rand_clause();
        logic [NV*2-1:0] c = '0;
        for (int v = 0; v < NV; v++) begin
            int r = $urandom_range(0, 5);
            if (r == 0)      c[2*v +: 2] = 2'b01;
            else if (r == 1) c[2*v +: 2] = 2'b10;
        end
        return c;
    endfunction

    function automatic logic [NV*3-1:0] rand_vals();
        logic [NV*3-1:0] x = '0;
        for (int v = 0; v < NV; v++) begin
            int r = $urandom_range(0, 2);
            x[3*v +: 2] = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b10;
            x[3*v+2]    = 1'($urandom_range(0, 1));
        end
        return x;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1; var_value_i = '0; wr_i = '0; rd_i = '0; clause_i = '0; clause_len_i = '0;
        start_i = 0; apply_impl_i = 0; apply_bkt_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_results", {conflict_o, imp_valid_o, all_c_sat_o}, 0);
        check("rst_idx_lit", {conflict_idx_o, imp_idx_o, imp_lit_o}, 0);
        check_reads('1);

        // (x0), (~x0 | x1), (x1 | x2) with x0 true: slot 1 implies x1.
        write_slot(0, 16'h0001, 4'd1);
        write_slot(1, 16'h0006, 4'd2);
        write_slot(2, 16'h0014, 4'd2);
        run_scan(24'h000001);
        check("imp_lit_x1_pos", imp_lit_o, 16'h0004);
        check("imp_idx_is_1", imp_idx_o, 1);

        apply_cmd(1, 0);
        check("len1_masked", clause_len_o[7:4], 0);
        run_scan(24'h000000);
        apply_cmd(0, 1);
        check("len1_restored", clause_len_o[7:4], 2);
        check_reads(8'h07);

        write_slot(3, 16'h0002, 4'd1);
        run_scan(24'h000001);
        check("conflict_idx_is_3", conflict_idx_o, 3);

        rst = 1; #1 rst = 0; model_reset();
        run_scan(24'h000000);
        check("empty_all_sat", all_c_sat_o, 1);

        for (int it = 0; it < 25; it++) begin
            repeat ($urandom_range(1, 3))
                write_slot($urandom_range(0, NC-1), rand_clause(), WL'($urandom));
            run_scan(rand_vals());
            apply_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_reads(NC'($urandom));
        end

        // Reset in the middle of a scan, while slot 4 is being evaluated.
        for (int s = 0; s < NC; s++) write_slot(s, rand_clause() | 16'h0001, WL'(s + 1));
        var_value_i = rand_vals(); start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
        repeat (4) @(posedge clk);
        #2 rst = 1;
        #1;
        model_reset();
        check("midscan_busy", busy_o, 0);
        check("midscan_results", {done_o, conflict_o, imp_valid_o, all_c_sat_o}, 0);
        check("midscan_idx_lit", {conflict_idx_o, imp_idx_o, imp_lit_o}, 0);
        check_reads('1);
        @(posedge clk); #1 rst = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
